// File: rtl/cv32e40p_register_file_scrubber.sv
// Background scrubber for the SEC-protected register file: walks words 1..NUM_WORDS-1,
// samples the decoder and writes corrected data back on idle write-port cycles.
module cv32e40p_register_file_scrubber #(
    parameter int unsigned ADDR_WIDTH     = 5,
    parameter int unsigned NUM_WORDS      = 32,
    parameter int unsigned SCRUB_INTERVAL = 256,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scrub_en_i,
    input  logic                  core_we_i,
    input  logic [ADDR_WIDTH-1:0] core_waddr_i,
    output logic                  scrub_re_o,
    output logic [ADDR_WIDTH-1:0] scrub_raddr_o,
    input  logic [31:0]           dec_data_i,
    input  logic                  dec_fault_i,
    output logic                  scrub_we_o,
    output logic [ADDR_WIDTH-1:0] scrub_waddr_o,
    output logic [31:0]           scrub_wdata_o,
    output logic                  busy_o,
    output logic                  pass_done_o,
    output logic [CNT_WIDTH-1:0]  corr_cnt_o
);
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned IVL_WIDTH  = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;

    localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(NUM_WORDS - 1);
    localparam logic [IVL_WIDTH-1:0]  IVL_RELOAD = IVL_WIDTH'(SCRUB_INTERVAL - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX    = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_READ,
        S_CHECK,
        S_WRITE,
        S_ADV
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [IVL_WIDTH-1:0]    ivl_q, ivl_d;
    logic                    stale_q, stale_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    fault_q, fault_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    re_q, re_d;
    logic [ADDR_WIDTH-1:0]   raddr_q, raddr_d;
    logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    busy_q, busy_d;
    logic                    pass_q, pass_d;
    logic                    stale_hit;

    // A core write to the word under scrub makes the sampled data obsolete.
    assign stale_hit = core_we_i && (core_waddr_i == addr_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= FIRST_ADDR;
            ivl_q   <= '0;
            stale_q <= 1'b0;
            data_q  <= '0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
            re_q    <= 1'b0;
            raddr_q <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ivl_q   <= ivl_d;
            stale_q <= stale_d;
            data_q  <= data_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
            re_q    <= re_d;
            raddr_q <= raddr_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        ivl_d      = ivl_q;
        stale_d    = stale_q;
        data_d     = data_q;
        fault_d    = fault_q;
        cnt_d      = cnt_q;
        scrub_we_o = 1'b0;

        case (state_q)
            S_IDLE: begin
                stale_d = 1'b0;
                if (scrub_en_i) begin
                    ivl_d   = IVL_RELOAD;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                stale_d = 1'b0;
                if (!scrub_en_i) begin
                    state_d = S_IDLE;
                end else if (ivl_q == '0) begin
                    state_d = S_READ;
                end else begin
                    ivl_d = ivl_q - IVL_WIDTH'(1);
                end
            end
            S_READ: begin
                stale_d = stale_q || stale_hit;
                data_d  = dec_data_i;
                fault_d = dec_fault_i;
                state_d = scrub_en_i ? S_CHECK : S_IDLE;
            end
            S_CHECK: begin
                stale_d = stale_q || stale_hit;
                if (!scrub_en_i) begin
                    state_d = S_IDLE;
                end else if (fault_q && !stale_d) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_ADV;
                end
            end
            S_WRITE: begin
                stale_d = stale_q || stale_hit;
                if (stale_q) begin
                    state_d = S_ADV;
                end else if (!core_we_i) begin
                    scrub_we_o = 1'b1;
                    cnt_d      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_WIDTH'(1);
                    state_d    = S_ADV;
                end
            end
            S_ADV: begin
                stale_d = 1'b0;
                addr_d  = (addr_q == LAST_ADDR) ? FIRST_ADDR : addr_q + ADDR_WIDTH'(1);
                ivl_d   = IVL_RELOAD;
                state_d = scrub_en_i ? S_WAIT : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Registered outputs are computed from the state being entered.
        re_d    = (state_d == S_READ);
        raddr_d = re_d ? addr_q : '0;
        waddr_d = (state_d == S_WRITE) ? addr_q : '0;
        wdata_d = (state_d == S_WRITE) ? data_d : '0;
        busy_d  = (state_d != S_IDLE);
        pass_d  = (state_d == S_ADV) && (addr_q == LAST_ADDR);
    end

    assign scrub_re_o    = re_q;
    assign scrub_raddr_o = raddr_q;
    assign scrub_waddr_o = waddr_q;
    assign scrub_wdata_o = wdata_q;
    assign busy_o        = busy_q;
    assign pass_done_o   = pass_q;
    assign corr_cnt_o    = cnt_q;

endmodule

// File: tb/tb_cv32e40p_register_file_scrubber.sv
// Randomized bench for the register file scrubber against a behavioural register file
// and step-level model (address walk, latency, saturating correction count).
module tb_cv32e40p_register_file_scrubber;
    localparam int unsigned AW = 5;
    localparam int unsigned NW = 32;
    localparam int unsigned SI = 4;
    localparam int unsigned CW = 2;
    localparam int CNT_SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          scrub_en_i;
    logic          core_we_i;
    logic [AW-1:0] core_waddr_i;
    logic          scrub_re_o;
    logic [AW-1:0] scrub_raddr_o;
    logic [31:0]   dec_data_i;
    logic          dec_fault_i;
    logic          scrub_we_o;
    logic [AW-1:0] scrub_waddr_o;
    logic [31:0]   scrub_wdata_o;
    logic          busy_o;
    logic          pass_done_o;
    logic [CW-1:0] corr_cnt_o;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int pass_cnt = 0;
    int exp_addr;
    int exp_cnt;

    logic [31:0] mem_data [NW];
    logic        fault_mask [NW];

    cv32e40p_register_file_scrubber #(
        .ADDR_WIDTH(AW), .NUM_WORDS(NW), .SCRUB_INTERVAL(SI), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .scrub_en_i(scrub_en_i), .core_we_i(core_we_i),
        .core_waddr_i(core_waddr_i), .scrub_re_o(scrub_re_o), .scrub_raddr_o(scrub_raddr_o),
        .dec_data_i(dec_data_i), .dec_fault_i(dec_fault_i), .scrub_we_o(scrub_we_o),
        .scrub_waddr_o(scrub_waddr_o), .scrub_wdata_o(scrub_wdata_o), .busy_o(busy_o),
        .pass_done_o(pass_done_o), .corr_cnt_o(corr_cnt_o)
    );

    always #5 clk = ~clk;

    // Decoder model: corrected data plus fault flag of the addressed word.
    always_comb begin
        dec_data_i  = scrub_re_o ? mem_data[scrub_raddr_o] : 32'h0;
        dec_fault_i = scrub_re_o && fault_mask[scrub_raddr_o];
    end

    always @(negedge clk) begin
        if (scrub_we_o === 1'b1) we_cnt <= we_cnt + 1;
        if (pass_done_o === 1'b1) pass_cnt <= pass_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_re(output int cyc);
        cyc = 0;
        while (scrub_re_o !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    task automatic next_read(output int cyc);
        int c;
        tick();
        wait_re(c);
        cyc = c + 1;
    endtask

    function automatic int next_addr(input int a);
        return (a % (NW - 1)) + 1;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; scrub_en_i = 1'b0; core_we_i = 1'b0; core_waddr_i = '0;
        for (int i = 0; i < NW; i++) begin
            mem_data[i] = $urandom; fault_mask[i] = 1'b0;
        end
        tick(); tick();
        checks++;
        if ({scrub_re_o, scrub_raddr_o, scrub_we_o, scrub_waddr_o, scrub_wdata_o,
             busy_o, pass_done_o, corr_cnt_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b re=%b raddr=%0d corr=%0d required all zero",
                     busy_o, scrub_re_o, scrub_raddr_o, corr_cnt_o);
        end
        rst_n = 1'b1;
        tick();
        exp_addr = 1; exp_cnt = 0;
    endtask

    task automatic test_walk();
        int cyc, w0, p0;
        w0 = we_cnt; p0 = pass_cnt;
        scrub_en_i = 1'b1;
        wait_re(cyc);
        checks++;
        if (cyc !== SI + 1 || scrub_raddr_o !== AW'(exp_addr)) begin
            errors++;
            $display("FAIL walk_first: cyc=%0d addr=%0d required cyc=%0d addr=%0d",
                     cyc, scrub_raddr_o, SI + 1, exp_addr);
        end
        for (int i = 0; i < NW - 1; i++) begin
            next_read(cyc);
            exp_addr = next_addr(exp_addr);
            checks++;
            if (cyc !== SI + 3 || scrub_raddr_o !== AW'(exp_addr)) begin
                errors++;
                $display("FAIL walk_step: cyc=%0d addr=%0d required cyc=%0d addr=%0d",
                         cyc, scrub_raddr_o, SI + 3, exp_addr);
            end
        end
        checks++;
        if (pass_cnt - p0 !== 1 || we_cnt - w0 !== 0 || corr_cnt_o !== CW'(0)) begin
            errors++;
            $display("FAIL walk_summary: passes=%0d writes=%0d corr=%0d required 1 0 0",
                     pass_cnt - p0, we_cnt - w0, corr_cnt_o);
        end
    endtask

    task automatic walk_to(input int target);
        int cyc;
        int n = 0;
        while (exp_addr != target && n < NW) begin
            next_read(cyc);
            exp_addr = next_addr(exp_addr);
            n++;
        end
        checks++;
        if (scrub_raddr_o !== AW'(target) || scrub_re_o !== 1'b1) begin
            errors++;
            $display("FAIL walk_to: addr=%0d re=%b required addr=%0d re=1",
                     scrub_raddr_o, scrub_re_o, target);
        end
    endtask

    task automatic test_single_fault();
        int cyc, w0;
        fault_mask[5] = 1'b1; mem_data[5] = 32'hDEADBEEF;
        walk_to(5);
        w0 = we_cnt;
        tick(); tick();
        checks++;
        if (scrub_we_o !== 1'b1 || scrub_waddr_o !== AW'(5) || scrub_wdata_o !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL fault_write: we=%b waddr=%0d wdata=%h required 1 5 deadbeef",
                     scrub_we_o, scrub_waddr_o, scrub_wdata_o);
        end
        tick();
        fault_mask[5] = 1'b0;
        exp_cnt = (exp_cnt + 1 > CNT_SAT) ? CNT_SAT : exp_cnt + 1;
        checks++;
        if (corr_cnt_o !== CW'(exp_cnt) || we_cnt - w0 !== 1) begin
            errors++;
            $display("FAIL fault_commit: corr=%0d writes=%0d required %0d 1",
                     corr_cnt_o, we_cnt - w0, exp_cnt);
        end
        wait_re(cyc);
        exp_addr = next_addr(exp_addr);
        checks++;
        if (cyc + 3 !== SI + 4 || scrub_raddr_o !== AW'(exp_addr)) begin
            errors++;
            $display("FAIL fault_latency: cyc=%0d addr=%0d required cyc=%0d addr=%0d",
                     cyc + 3, scrub_raddr_o, SI + 4, exp_addr);
        end
    endtask

    task automatic test_core_priority();
        int w0;
        fault_mask[8] = 1'b1; mem_data[8] = $urandom;
        walk_to(8);
        w0 = we_cnt;
        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            core_we_i = 1'b1; core_waddr_i = AW'(9);
            #1;
            checks++;
            if (scrub_we_o !== 1'b0 || busy_o !== 1'b1 || scrub_waddr_o !== AW'(8)) begin
                errors++;
                $display("FAIL prio_stall: we=%b busy=%b waddr=%0d required 0 1 8",
                         scrub_we_o, busy_o, scrub_waddr_o);
            end
        end
        tick();
        core_we_i = 1'b0;
        #1;
        checks++;
        if (scrub_we_o !== 1'b1 || scrub_wdata_o !== mem_data[8]) begin
            errors++;
            $display("FAIL prio_release: we=%b wdata=%h required 1 %h",
                     scrub_we_o, scrub_wdata_o, mem_data[8]);
        end
        tick();
        fault_mask[8] = 1'b0;
        exp_cnt = (exp_cnt + 1 > CNT_SAT) ? CNT_SAT : exp_cnt + 1;
        checks++;
        if (corr_cnt_o !== CW'(exp_cnt) || we_cnt - w0 !== 1) begin
            errors++;
            $display("FAIL prio_commit: corr=%0d writes=%0d required %0d 1",
                     corr_cnt_o, we_cnt - w0, exp_cnt);
        end
    endtask

    task automatic test_stale();
        int cyc, w0;
        fault_mask[10] = 1'b1; mem_data[10] = $urandom;
        walk_to(10);
        w0 = we_cnt;
        tick();
        core_we_i = 1'b1; core_waddr_i = AW'(10);
        fault_mask[10] = 1'b0; mem_data[10] = $urandom;
        tick();
        core_we_i = 1'b0;
        next_read(cyc);
        exp_addr = next_addr(exp_addr);
        checks++;
        if (we_cnt - w0 !== 0 || corr_cnt_o !== CW'(exp_cnt) || scrub_raddr_o !== AW'(exp_addr)) begin
            errors++;
            $display("FAIL stale_abort: writes=%0d corr=%0d addr=%0d required 0 %0d %0d",
                     we_cnt - w0, corr_cnt_o, scrub_raddr_o, exp_cnt, exp_addr);
        end
    endtask

    task automatic test_enable_drop();
        int cyc, idle;
        walk_to(11);
        tick(); tick(); tick();
        scrub_en_i = 1'b0;
        exp_addr = next_addr(exp_addr);
        tick();
        idle = $urandom_range(2, 10);
        for (int i = 0; i < idle; i++) begin
            checks++;
            if (busy_o !== 1'b0 || scrub_re_o !== 1'b0) begin
                errors++;
                $display("FAIL disable_idle: busy=%b re=%b required 0 0", busy_o, scrub_re_o);
            end
            tick();
        end
        scrub_en_i = 1'b1;
        wait_re(cyc);
        checks++;
        if (cyc !== SI + 1 || scrub_raddr_o !== AW'(exp_addr)) begin
            errors++;
            $display("FAIL reenable: cyc=%0d addr=%0d required cyc=%0d addr=%0d",
                     cyc, scrub_raddr_o, SI + 1, exp_addr);
        end
    endtask

    task automatic test_reset_mid_write();
        int cyc;
        int tgt = next_addr(exp_addr);
        fault_mask[tgt] = 1'b1; mem_data[tgt] = $urandom | 32'h1;
        walk_to(tgt);
        tick(); tick();
        core_we_i = 1'b1; core_waddr_i = AW'(20);
        #1;
        checks++;
        if (busy_o !== 1'b1 || scrub_waddr_o !== AW'(tgt) || scrub_we_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_pre: busy=%b waddr=%0d we=%b required 1 %0d 0",
                     busy_o, scrub_waddr_o, scrub_we_o, tgt);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({scrub_re_o, scrub_raddr_o, scrub_we_o, scrub_waddr_o, scrub_wdata_o,
             busy_o, pass_done_o, corr_cnt_o} !== '0) begin
            errors++;
            $display("FAIL rst_async: busy=%b waddr=%0d wdata=%h corr=%0d required all zero",
                     busy_o, scrub_waddr_o, scrub_wdata_o, corr_cnt_o);
        end
        core_we_i = 1'b0; scrub_en_i = 1'b0; fault_mask[tgt] = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        exp_addr = 1; exp_cnt = 0;
        scrub_en_i = 1'b1;
        wait_re(cyc);
        checks++;
        if (cyc !== SI + 1 || scrub_raddr_o !== AW'(1) || corr_cnt_o !== CW'(0)) begin
            errors++;
            $display("FAIL rst_restart: cyc=%0d addr=%0d corr=%0d required %0d 1 0",
                     cyc, scrub_raddr_o, corr_cnt_o, SI + 1);
        end
    endtask

    task automatic test_saturate();
        int cyc;
        for (int a = 2; a < 10; a++) begin
            fault_mask[a] = (a < 6) ? 1'b1 : 1'($urandom_range(0, 1));
            mem_data[a] = $urandom;
        end
        while (exp_addr < 9) begin
            next_read(cyc);
            exp_addr = next_addr(exp_addr);
            checks++;
            if (scrub_raddr_o !== AW'(exp_addr)) begin
                errors++;
                $display("FAIL sat_addr: addr=%0d required %0d", scrub_raddr_o, exp_addr);
            end
            if (fault_mask[exp_addr]) begin
                tick(); tick();
                checks++;
                if (scrub_we_o !== 1'b1 || scrub_waddr_o !== AW'(exp_addr) ||
                    scrub_wdata_o !== mem_data[exp_addr]) begin
                    errors++;
                    $display("FAIL sat_write: we=%b waddr=%0d wdata=%h required 1 %0d %h",
                             scrub_we_o, scrub_waddr_o, scrub_wdata_o, exp_addr, mem_data[exp_addr]);
                end
                tick();
                fault_mask[exp_addr] = 1'b0;
                exp_cnt = (exp_cnt + 1 > CNT_SAT) ? CNT_SAT : exp_cnt + 1;
                checks++;
                if (corr_cnt_o !== CW'(exp_cnt)) begin
                    errors++;
                    $display("FAIL sat_count: corr=%0d required %0d", corr_cnt_o, exp_cnt);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_walk();
        test_single_fault();
        test_core_priority();
        test_stale();
        test_enable_drop();
        test_reset_mid_write();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
